// File: rtl/alu_seq.sv
// alu_seq: falling-edge sequential ALU with operand/result registers, flags and a shift-add multiplier.
// G is driven back onto the shared bus through a tri-state output.
module alu_seq #(
    parameter int WIDTH = 10,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLKb,
    input  logic             RSTb,
    input  logic [WIDTH-1:0] OP,
    input  logic [3:0]       FN,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       FLAGS
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t             state_q;
    logic [WIDTH-1:0]   a_q, g_q, mplier_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_d;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         flags_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   r;
    logic               c, v, big;
    logic [WIDTH:0]     sum, diff, shl, shr;
    logic [SHW-1:0]     sh;
    always_comb begin
        sum    = {1'b0, OP} + {1'b0, a_q};
        diff   = {1'b0, OP} - {1'b0, a_q};
        sh     = a_q[SHW-1:0];
        big    = a_q >= WIDTH'(WIDTH);
        shl    = {1'b0, OP} << sh;
        shr    = {OP, 1'b0} >> sh;
        prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (FN)
            4'b0001: begin
                {c, r} = sum;
                v = (OP[WIDTH-1] == a_q[WIDTH-1]) && (sum[WIDTH-1] != OP[WIDTH-1]);
            end
            4'b0010, 4'b1001: begin
                r = diff[WIDTH-1:0];
                c = ~diff[WIDTH];
                v = (OP[WIDTH-1] != a_q[WIDTH-1]) && (diff[WIDTH-1] != OP[WIDTH-1]);
            end
            4'b0011: r = OP & a_q;
            4'b0100: r = OP | a_q;
            4'b0101: r = OP ^ a_q;
            // the extra bit beside the shifted operand catches the last bit shifted out
            4'b0110: {c, r} = big ? '0 : shl;
            4'b0111: {r, c} = big ? '0 : shr;
            default: ;
        endcase
    end
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            g_q      <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_MUL) begin
                prod_q   <= prod_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    g_q     <= prod_d[WIDTH-1:0];
                    flags_q <= {prod_d[WIDTH-1:0] == '0, prod_d[WIDTH-1], |prod_d[2*WIDTH-1:WIDTH], 1'b0};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            end else begin
                if (Ain)
                    a_q <= OP;
                if (Gin && FN == 4'b1000) begin
                    state_q  <= S_MUL;
                    busy_q   <= 1'b1;
                    prod_q   <= '0;
                    mcand_q  <= {{WIDTH{1'b0}}, OP};
                    mplier_q <= a_q;
                    cnt_q    <= CW'(WIDTH);
                end else if (Gin) begin
                    if (FN != 4'b1001)
                        g_q <= r;
                    flags_q <= {r == '0, r[WIDTH-1], c, v};
                end
            end
        end
    end
    assign Q     = Gout ? g_q : 'z;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign FLAGS = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with an arithmetic reference model and per-cycle compare.
module tb_alu_seq;
    localparam int W = 10;
    localparam int M = 1 << W;
    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] op = '0;
    logic [3:0]   fn = '0;
    logic         ain = 1'b0, gin = 1'b0, gout = 1'b1;
    tri1  [W-1:0] q;
    logic         busy, done;
    logic [3:0]   flags;
    int cmp_n = 0, err_n = 0, edges = 0;
    int m_a = 0, m_g = 0, m_busy = 0, m_done = 0, m_left = 0, m_op_l = 0, m_a_l = 0;
    logic [3:0] m_flags = '0;

    alu_seq #(.WIDTH(W)) dut (
        .CLKb(clk), .RSTb(rstn), .OP(op), .FN(fn), .Ain(ain), .Gin(gin), .Gout(gout),
        .Q(q), .BUSY(busy), .DONE(done), .FLAGS(flags)
    );

    always #5 clk = ~clk;
    always @(negedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sv(input int x);
        return x >= M / 2 ? x - M : x;
    endfunction

    function automatic void model_op(input int f, input int o, input int a, output int r, output logic [3:0] fl);
        int c, v, s;
        r = 0; c = 0; v = 0;
        case (f)
            1: begin s = o + a; r = s % M; c = int'(s >= M); s = sv(o) + sv(a); v = int'(s < -M / 2 || s >= M / 2); end
            2, 9: begin r = (o - a + M) % M; c = int'(o >= a); s = sv(o) - sv(a); v = int'(s < -M / 2 || s >= M / 2); end
            3: r = o & a;
            4: r = o | a;
            5: r = o ^ a;
            6: if (a < W) begin r = (o << a) % M; c = ((o << a) >> W) & 1; end
            7: if (a < W) begin r = o >> a; c = a > 0 ? (o >> (a - 1)) & 1 : 0; end
            default: r = 0;
        endcase
        fl = {r == 0, r >= M / 2, c[0], v[0]};
    endfunction

    always @(negedge clk or negedge rstn) begin : model
        int r;
        logic [3:0] fl;
        longint p;
        if (!rstn) begin
            m_a <= 0; m_g <= 0; m_flags <= '0; m_busy <= 0; m_done <= 0; m_left <= 0;
        end else begin
            m_done <= 0;
            if (m_busy != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    p = longint'(m_op_l) * longint'(m_a_l);
                    r = int'(p % M);
                    m_g <= r;
                    m_flags <= {r == 0, r >= M / 2, p >= M, 1'b0};
                    m_busy <= 0;
                    m_done <= 1;
                end
            end else begin
                if (gin && fn == 4'd8) begin
                    m_busy <= 1; m_left <= W; m_op_l <= int'(op); m_a_l <= m_a;
                end else if (gin) begin
                    model_op(int'(fn), int'(op), m_a, r, fl);
                    if (fn != 4'd9) m_g <= r;
                    m_flags <= fl;
                end
                if (ain) m_a <= int'(op);
            end
        end
    end

    always @(posedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("flags", flags, m_flags);
        check("q", q, gout ? m_g : M - 1);
    end

    task automatic step(input logic a_in, input logic g_in, input logic [3:0] f, input logic [W-1:0] o);
        @(posedge clk);
        ain = a_in; gin = g_in; fn = f; op = o;
        @(negedge clk);
        #2;
        ain = 1'b0; gin = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #2;
            if (done) break;
        end
        check("mul_done_seen", done, 1);
    endtask

    initial begin
        int n;
        int seen;
        #1 rstn = 1'b0;
        #3;
        check("rst_q", q, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        #3 rstn = 1'b1;
        step(1, 0, 0, 10'h3FF);
        step(0, 1, 1, 10'h001);
        check("add_ovf_q", q, 10'h000);
        check("add_ovf_flags", flags, 4'b1010);
        step(1, 0, 0, 7);
        step(0, 1, 2, 5);
        check("sub_neg_q", q, 10'h3FE);
        check("sub_neg_flags", flags, 4'b0100);
        step(0, 1, 9, 7);
        check("cmp_q", q, 10'h3FE);
        check("cmp_flags", flags, 4'b1010);
        step(1, 1, 1, 2);
        check("ain_gin_old_a", q, 9);
        step(0, 1, 1, 0);
        check("ain_gin_new_a", q, 2);
        step(1, 0, 0, 10'h1FF);
        step(0, 1, 1, 10'h001);
        check("add_sovf_flags", flags, 4'b0101);
        step(1, 0, 0, 1);
        step(0, 1, 2, 10'h200);
        check("sub_sovf_q", q, 10'h1FF);
        check("sub_sovf_flags", flags, 4'b0011);
        step(0, 1, 5, 10'h3FF);
        check("xor_q", q, 10'h3FE);
        step(0, 1, 3, 10'h3FF);
        step(0, 1, 4, 10'h200);
        step(0, 1, 6, 10'h201);
        check("shl_q", q, 10'h002);
        check("shl_flags", flags, 4'b0010);
        step(0, 1, 7, 10'h003);
        step(0, 1, 0, 10'h123);
        check("bad_fn_flags", flags, 4'b1000);
        step(0, 1, 15, 5);
        step(1, 0, 0, 0);
        step(0, 1, 6, 10'h2AB);
        step(1, 0, 0, 9);
        step(0, 1, 6, 10'h001);
        step(1, 0, 0, 10);
        step(0, 1, 6, 10'h3FF);
        step(1, 0, 0, 12);
        step(0, 1, 7, 10'h3FF);
        check("shr_big_q", q, 0);
        check("shr_big_flags", flags, 4'b1000);
        step(1, 0, 0, 30);
        step(0, 1, 1, 1);
        step(0, 1, 8, 25);
        n = edges;
        check("mul_busy", busy, 1);
        step(1, 0, 0, 10'h155);
        step(0, 1, 1, 1);
        check("mul_q_old_g", q, 10'h01F);
        gout = 1'b0;
        #1 check("q_highz", q, 10'h3FF);
        gout = 1'b1;
        wait_done();
        check("mul_latency", edges - n, W);
        check("mul_q", q, 10'h2EE);
        check("mul_flags", flags, 4'b0100);
        step(0, 1, 1, 0);
        check("mul_done_pulse", done, 0);
        check("a_kept", q, 30);
        step(0, 1, 8, 40);
        wait_done();
        check("mul_ovf_q", q, 10'h0B0);
        check("mul_ovf_flags", flags, 4'b0010);
        step(0, 1, 8, 25);
        repeat (4) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_q", q, 0);
        check("mrst_flags", flags, 0);
        check("mrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #2;
            if (done) seen = 1;
        end
        check("mrst_no_done", seen, 0);
        step(0, 1, 1, 5);
        check("post_rst_add", q, 5);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the datapath bus. It holds an operand register A and a result register G, and adds XOR, shifts, compare and an iterative multiply to the four single-cycle operations. Condition flags are also provided. The block sits on the shared datapath bus: it takes operands from the bus, and it drives G back onto the bus through a tri-state output when commanded by the control unit.

## Interface
Parameters:
- WIDTH, 10: data width of OP, A, G and Q; legal range 4 to 32.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from A.

Ports:
- CLKb  in  1  clock; all state updates on the falling edge
- RSTb  in  1  reset, asynchronous, active-low
- OP  in  WIDTH  operand from the bus
- FN  in  4  encoded function select, sampled with Gin
- Ain  in  1  load A from OP
- Gin  in  1  start the operation selected by FN
- Gout  in  1  drive G onto Q
- Q  out  WIDTH  tri-state bus output; G when Gout=1, else high-Z
- BUSY  out  1  multiply in progress
- DONE  out  1  one-cycle pulse when a multiply result lands in G
- FLAGS  out  4  {Z, N, C, V}, registered

## Operation
Function codes; R is the result, OP is the left operand, A is the right operand:
- 0001 ADD: R = OP+A. C = carry out. V = signed overflow.
- 0010 SUB: R = OP−A. C = 1 when OP ≥ A unsigned (no borrow). V = signed overflow.
- 0011 AND, 0100 OR, 0101 XOR: C = 0, V = 0.
- 0110 SHL: R = OP << A.
- 0111 SHR: R = OP >> A, logical shift.
  - Shift amount is A unsigned; an amount ≥ WIDTH gives R = 0 and C = 0.
  - C = last bit shifted out; an amount of 0 gives C = 0. V = 0.
- 1000 MUL: R = low WIDTH bits of OP×A, unsigned, computed by shift-add.
  - C = 1 if the high WIDTH bits of the product are nonzero. V = 0.
- 1001 CMP: computed as SUB, but only FLAGS are updated; G is unchanged.
- All other codes: R = 0. FLAGS = {1, 0, 0, 0}.
- Z = (R == 0) and N = R[WIDTH−1] for every code.

Register behaviour:
- Ain=1 at a falling edge while idle: A <= OP.
- Gin=1 at a falling edge while idle, single-cycle code: G <= R and FLAGS updated at that edge.
- Ain and Gin in the same edge: the operation uses the old A, and A then takes OP.
- Gin=1 with MUL while idle:
  - Operands are latched, an internal counter is loaded, and BUSY is set.
  - The block performs one shift-add step per falling edge.
- While BUSY=1:
  - Ain and Gin are ignored; A, G and FLAGS hold.
  - Gout still drives the old G.
- Q is combinational from Gout and G. There is no registering on the output path.

State machine:
- IDLE → MUL on Gin with FN = MUL.
- MUL → IDLE after WIDTH steps; G and FLAGS are written and DONE is pulsed on that transition.

Reset (RSTb=0, takes effect immediately):
- A = 0, G = 0, FLAGS = 0, BUSY = 0, DONE = 0, state = IDLE.
- An in-flight multiply is aborted with no write to G.
- Q follows Gout and the reset G (0 or high-Z).

## Timing
- Edge n is the falling edge at which Gin is sampled.
- Single-cycle operations: latency 1. G and FLAGS are valid after edge n, and Gout may read the result in the following cycle.
- MUL: BUSY rises after edge n. G, FLAGS and DONE update after edge n+WIDTH, and BUSY falls at the same edge.
  - DONE stays high for exactly one cycle.
  - A new Gin is accepted at edge n+WIDTH+1, not earlier.
- Gout to Q is a combinational path only.
- RSTb deassertion is synchronised externally; the first active edge is the first falling edge after RSTb goes high.

## Test plan
All scenarios use WIDTH=10.
- ADD overflow: A=0x3FF, OP=0x001, FN=0001, Gin → G=0x000, FLAGS Z=1, C=1, N=0, V=0, one edge later.
- SUB negative: A=7, OP=5, FN=0010 → G=0x3FE, N=1, C=0, Z=0, V=0. Then CMP with OP=7 → Z=1, C=1, G still 0x3FE.
- Shifts:
  - SHL with A=1, OP=0x201 → G=0x002, C=1.
  - SHR with A=12, OP=0x3FF → G=0, C=0.
- MUL, result fits: A=30, OP=25, FN=1000 → BUSY for 10 edges, then G=0x2EE, C=0, DONE high for one cycle.
- MUL, result overflows: A=30, OP=40 → G=0x0B0, C=1.
- MUL interference:
  - Ain and Gin pulses during BUSY are ignored; A and G are unchanged.
  - Gout=1 during BUSY drives the old G.
  - Gout=0 → Q is high-Z.
- Reset mid-multiply: assert RSTb=0 at step 4 → BUSY=0, G=0, FLAGS=0 immediately, and DONE never pulses.
